// File: rtl/pwm_pkg.sv
// Shared widths, configuration payload and reset constants for the PWM timebase slice.
package pwm_pkg;

  localparam int unsigned WIDTH  = 17;
  localparam int unsigned HRBITS = 3;
  localparam int unsigned CW     = WIDTH - HRBITS;

  // Period/compare configuration as written by the host and as seen by the OC block.
  typedef struct packed {
    logic [CW-1:0]    period;
    logic [WIDTH-1:0] cmpH;
    logic [WIDTH-1:0] cmpL;
  } pwm_cfg_t;

  localparam logic [CW-1:0]    PER_RST  = 14'd255;
  localparam logic [WIDTH-1:0] CMPH_RST = 17'd0;
  localparam logic [WIDTH-1:0] CMPL_RST = 17'd50;

  localparam pwm_cfg_t CFG_RST = '{period: PER_RST, cmpH: CMPH_RST, cmpL: CMPL_RST};

  // A configuration is unusable if the period is zero or either coarse compare lies past it.
  function automatic logic cfg_bad(input pwm_cfg_t c);
    return (c.period == '0)
        || (c.cmpH[WIDTH-1:HRBITS] > c.period)
        || (c.cmpL[WIDTH-1:HRBITS] > c.period);
  endfunction

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Single-entry configuration shadow: valid/ready accept, validation, and commit to the
// active configuration on a wrap (or immediately while the timebase is stopped).
// Ports: clk/rst; en, wrap from the timebase; wr_valid/wr_cfg host request;
// wr_ready, wr_err, pending status; cfg_act active configuration.
module pwm_cfg_shadow
  import pwm_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     wrap,
  input  logic     wr_valid,
  input  pwm_cfg_t wr_cfg,
  output logic     wr_ready,
  output logic     wr_err,
  output logic     pending,
  output pwm_cfg_t cfg_act
);

  logic     pending_d,  pending_q;
  logic     wr_ready_d, wr_ready_q;
  logic     wr_err_d,   wr_err_q;
  pwm_cfg_t shadow_d,   shadow_q;
  pwm_cfg_t act_d,      act_q;
  logic     accept_c, bad_c, commit_c;

  // Accept/validate/commit; accept needs !pending and commit needs pending, so they never coincide.
  always_comb begin
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    act_d      = act_q;
    accept_c   = wr_valid && !pending_q;
    bad_c      = cfg_bad(wr_cfg);
    commit_c   = pending_q && (wrap || !en);
    wr_err_d   = accept_c && bad_c;

    if (commit_c) begin
      act_d     = shadow_q;
      pending_d = 1'b0;
    end
    if (accept_c && !bad_c) begin
      shadow_d  = wr_cfg;
      pending_d = 1'b1;
    end
    wr_ready_d = !pending_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b1;
      wr_err_q   <= 1'b0;
      shadow_q   <= CFG_RST;
      act_q      <= CFG_RST;
    end else begin
      pending_q  <= pending_d;
      wr_ready_q <= wr_ready_d;
      wr_err_q   <= wr_err_d;
      shadow_q   <= shadow_d;
      act_q      <= act_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign wr_err   = wr_err_q;
  assign pending  = pending_q;
  assign cfg_act  = act_q;

endmodule

// File: rtl/pwm_tb_ctrl.sv
// Coarse timebase for the high-resolution PWM output compare, with glitch-free config
// commit at the period wrap and a missed-falling-edge monitor.
// Ports: clk/rst; en run enable; wr_* host write (valid/ready, err pulse); falling strobe
// from OC; tb timebase, cmpH/cmpL active compares, tc period-start, fall_miss, pending.
module pwm_tb_ctrl
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CW-1:0]    wr_period,
  input  logic [WIDTH-1:0] wr_cmpH,
  input  logic [WIDTH-1:0] wr_cmpL,
  output logic             wr_err,
  input  logic             falling,
  output logic [CW-1:0]    tb,
  output logic [WIDTH-1:0] cmpH,
  output logic [WIDTH-1:0] cmpL,
  output logic             tc,
  output logic             fall_miss,
  output logic             pending
);

  logic [CW-1:0] tb_d, tb_q;
  logic          tc_d, tc_q;
  logic          armed_d, armed_q;
  logic          fall_seen_d, fall_seen_q;
  logic          fall_miss_d, fall_miss_q;
  logic          wrap_c;
  pwm_cfg_t      wr_cfg;
  pwm_cfg_t      cfg_act;

  assign wr_cfg = '{period: wr_period, cmpH: wr_cmpH, cmpL: wr_cmpL};

  pwm_cfg_shadow u_shadow (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wrap     (wrap_c),
    .wr_valid (wr_valid),
    .wr_cfg   (wr_cfg),
    .wr_ready (wr_ready),
    .wr_err   (wr_err),
    .pending  (pending),
    .cfg_act  (cfg_act)
  );

  // Timebase and miss monitor; armed keeps the partial first period after enable unflagged.
  always_comb begin
    wrap_c      = en && (tb_q == cfg_act.period);
    tb_d        = tb_q + CW'(1);
    tc_d        = wrap_c;
    armed_d     = armed_q;
    fall_seen_d = fall_seen_q || falling;
    fall_miss_d = wrap_c && armed_q && !fall_seen_q && !falling;

    if (!en) begin
      tb_d    = '0;
      armed_d = 1'b0;
    end else if (wrap_c) begin
      tb_d        = '0;
      armed_d     = 1'b1;
      fall_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_q        <= '0;
      tc_q        <= 1'b0;
      armed_q     <= 1'b0;
      fall_seen_q <= 1'b0;
      fall_miss_q <= 1'b0;
    end else begin
      tb_q        <= tb_d;
      tc_q        <= tc_d;
      armed_q     <= armed_d;
      fall_seen_q <= fall_seen_d;
      fall_miss_q <= fall_miss_d;
    end
  end

  assign tb        = tb_q;
  assign tc        = tc_q;
  assign fall_miss = fall_miss_q;
  assign cmpH      = cfg_act.cmpH;
  assign cmpL      = cfg_act.cmpL;

endmodule

// File: tb/tb_pwm_tb_ctrl.sv
// Randomized bench for pwm_tb_ctrl against a cycle-level behavioural reference model.
module tb_pwm_tb_ctrl;
  import pwm_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             wr_valid;
  logic             wr_ready;
  logic [CW-1:0]    wr_period;
  logic [WIDTH-1:0] wr_cmpH;
  logic [WIDTH-1:0] wr_cmpL;
  logic             wr_err;
  logic             falling;
  logic [CW-1:0]    tb;
  logic [WIDTH-1:0] cmpH;
  logic [WIDTH-1:0] cmpL;
  logic             tc;
  logic             fall_miss;
  logic             pending;

  pwm_tb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_period (wr_period),
    .wr_cmpH   (wr_cmpH),
    .wr_cmpL   (wr_cmpL),
    .wr_err    (wr_err),
    .falling   (falling),
    .tb        (tb),
    .cmpH      (cmpH),
    .cmpL      (cmpL),
    .tc        (tc),
    .fall_miss (fall_miss),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state kept as plain integers.
  int unsigned m_tb, m_per, m_ch, m_cl;
  int unsigned s_per, s_ch, s_cl;
  bit m_pend, m_tc, m_err, m_miss, m_armed, m_seen;
  bit last_acc;

  task automatic model_reset();
    m_tb = 0; m_per = 255; m_ch = 0; m_cl = 50;
    s_per = 0; s_ch = 0; s_cl = 0;
    m_pend = 0; m_tc = 0; m_err = 0; m_miss = 0; m_armed = 0; m_seen = 0;
    last_acc = 0;
  endtask

  task automatic check_all();
    chk("tb",        32'(tb),        m_tb);
    chk("tc",        32'(tc),        32'(m_tc));
    chk("cmpH",      32'(cmpH),      m_ch);
    chk("cmpL",      32'(cmpL),      m_cl);
    chk("wr_ready",  32'(wr_ready),  32'(!m_pend));
    chk("pending",   32'(pending),   32'(m_pend));
    chk("wr_err",    32'(wr_err),    32'(m_err));
    chk("fall_miss", 32'(fall_miss), 32'(m_miss));
  endtask

  // One clock of the specified behaviour, driven by the inputs currently applied.
  task automatic model_step();
    int unsigned p, hc, lc, old_per;
    bit wrap, acc, bad, cmt;
    p   = int'(wr_period);
    hc  = int'(wr_cmpH) / 8;
    lc  = int'(wr_cmpL) / 8;
    wrap = en && (m_tb == m_per);
    acc  = wr_valid && !m_pend;
    bad  = (p == 0) || (hc > p) || (lc > p);
    cmt  = m_pend && (wrap || !en);
    old_per = m_per;

    m_err  = acc && bad;
    m_miss = wrap && m_armed && !m_seen && !falling;
    m_tc   = wrap;
    if (cmt) begin
      m_per = s_per; m_ch = s_ch; m_cl = s_cl; m_pend = 0;
    end
    if (acc && !bad) begin
      s_per = p; s_ch = int'(wr_cmpH); s_cl = int'(wr_cmpL); m_pend = 1;
    end
    m_seen  = wrap ? 1'b0 : (m_seen || falling);
    m_armed = en && (m_armed || wrap);
    m_tb    = en ? (m_tb + 1) % (old_per + 1) : 0;
    last_acc = acc;
  endtask

  // Random write request; coarse compares may overshoot the period to exercise rejection.
  task automatic new_write();
    int unsigned p, hc, lc;
    p  = $urandom_range(0, 12);
    hc = $urandom_range(0, p + 1);
    lc = $urandom_range(0, p + 1);
    wr_period = CW'(p);
    wr_cmpH   = WIDTH'(hc * 8 + $urandom_range(0, 7));
    wr_cmpL   = WIDTH'(lc * 8 + $urandom_range(0, 7));
  endtask

  task automatic gen_inputs();
    if (!(wr_valid && !last_acc)) begin
      wr_valid = ($urandom_range(0, 7) == 0);
      if (wr_valid) new_write();
    end
    en      = ($urandom_range(0, 59) != 0);
    falling = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; falling = 1'b0;
    wr_period = '0; wr_cmpH = '0; wr_cmpL = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free-running default period, no writes, no falling strobes.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check_all();
      en = 1'b1;
      model_step();
    end

    // Random writes, enable drops, falling strobes and two mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check_all();
      if (i == 1203 || i == 2411) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        wr_valid = 1'b0;
        #4 rst = 1'b0;
        continue;
      end
      gen_inputs();
      model_step();
    end

    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
